// File: rtl/sweep_pkg.sv
// Shared definitions for the on-chip operand-sweep checker.
//   mode_t          : 3-bit operation selector driven into the checker
//   state_t         : checker FSM state encoding
//   sweep_cnt_width : width of the match/mismatch counters for a given
//                     operand width (one extra bit so the final count of
//                     2^(2*DATA_W) pairs fits without wrapping)
package sweep_pkg;

    typedef enum logic [2:0] {
        MODE_ADD  = 3'd0,
        MODE_SUB  = 3'd1,
        MODE_MUL  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XOR  = 3'd5,
        MODE_XNOR = 3'd6,
        MODE_BAD  = 3'd7
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD_A  = 4'd1,
        S_LOAD_B  = 4'd2,
        S_RUN     = 4'd3,
        S_READ_LO = 4'd4,
        S_READ_HI = 4'd5,
        S_CHECK   = 4'd6,
        S_TOUT    = 4'd7,
        S_NEXT    = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    function automatic int sweep_cnt_width(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/sweep_golden_alu.sv
// Combinational reference model for the tp1 operations.
//   mode   : operation (sweep_pkg::mode_t encoding)
//   a, b   : operands (a = inner loop value, b = outer loop value)
//   result : 2*DATA_W-bit golden value; only MUL uses the upper half,
//            every other mode returns its DATA_W-bit result zero-extended
module sweep_golden_alu
    import sweep_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]          mode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] result
);

    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] product;

    assign sum     = a + b;
    assign diff    = a - b;
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_comb begin
        result = '0;
        case (mode_t'(mode))
            MODE_ADD:  result = {{DATA_W{1'b0}}, sum};
            MODE_SUB:  result = {{DATA_W{1'b0}}, diff};
            MODE_MUL:  result = product;
            MODE_NAND: result = {{DATA_W{1'b0}}, ~(a & b)};
            MODE_NOR:  result = {{DATA_W{1'b0}}, ~(a | b)};
            MODE_XOR:  result = {{DATA_W{1'b0}}, a ^ b};
            MODE_XNOR: result = {{DATA_W{1'b0}}, ~(a ^ b)};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/op_sweep_checker.sv
// On-chip exhaustive operand sweep against the tp1 core.
// For every (i, j) pair: hold tp1 in reset, write j/i into data RAM,
// release tp1, wait for the DONE PC, read back the result and compare it
// with the golden model.
//   _iClk, _iReset     : clock, synchronous active-low reset
//   _iStart, _iMode    : start pulse (accepted in IDLE/DONE) and operation
//   _iInstMemAddr      : tp1 program counter
//   _iMemRData         : data RAM read data (combinational read)
//   _oMemAddr/_oMemWData/_oMemWrite : RAM bus while _oBusOwn=1
//   _oBusOwn           : 1 = checker owns the RAM bus
//   _oCpuReset         : active-high reset to tp1
//   _oBusy/_oDone      : sweep in progress / finished (level)
//   _oTimeout          : sticky, some pair never reached DONE
//   _oBadMode          : invalid mode requested
//   _oErrCnt/_oOkCnt   : mismatch / match counters
module op_sweep_checker
    import sweep_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int OPA_ADDR    = 0,
    parameter int OPB_ADDR    = 1,
    parameter int RES_ADDR    = 2,
    parameter int DONE_ADDR   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                _iClk,
    input  logic                _iReset,
    input  logic                _iStart,
    input  logic [2:0]          _iMode,
    input  logic [ADDR_W-1:0]   _iInstMemAddr,
    input  logic [DATA_W-1:0]   _iMemRData,
    output logic [ADDR_W-1:0]   _oMemAddr,
    output logic [DATA_W-1:0]   _oMemWData,
    output logic                _oMemWrite,
    output logic                _oBusOwn,
    output logic                _oCpuReset,
    output logic                _oBusy,
    output logic                _oDone,
    output logic                _oTimeout,
    output logic                _oBadMode,
    output logic [2*DATA_W:0]   _oErrCnt,
    output logic [2*DATA_W:0]   _oOkCnt
);

    localparam int CNT_W = sweep_cnt_width(DATA_W);
    localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [ADDR_W-1:0] OPA_A  = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OPB_A  = ADDR_W'(OPB_ADDR);
    localparam logic [ADDR_W-1:0] RESL_A = ADDR_W'(RES_ADDR);
    localparam logic [ADDR_W-1:0] RESH_A = ADDR_W'(RES_ADDR + 1);
    localparam logic [ADDR_W-1:0] DONE_A = ADDR_W'(DONE_ADDR);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t              state_reg, state_next;
    mode_t               mode_reg;
    logic [DATA_W-1:0]   i_reg, j_reg;
    logic [DATA_W-1:0]   res_lo_reg, res_hi_reg;
    logic [TO_W-1:0]     run_cnt_reg;
    logic [CNT_W-1:0]    err_cnt_reg, ok_cnt_reg;
    logic                timeout_reg, bad_mode_reg;

    logic [2*DATA_W-1:0] golden;
    logic                match;
    logic                start_ok;
    logic                last_pair;

    sweep_golden_alu #(
        .DATA_W (DATA_W)
    ) u_golden (
        .mode   (mode_reg),
        .a      (j_reg),
        .b      (i_reg),
        .result (golden)
    );

    assign match = (mode_reg == MODE_MUL) ? ({res_hi_reg, res_lo_reg} == golden)
                                          : (res_lo_reg == golden[DATA_W-1:0]);

    assign start_ok  = _iStart && (state_reg == S_IDLE || state_reg == S_DONE);
    assign last_pair = (&i_reg) && (&j_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_next = (_iMode == MODE_BAD) ? S_DONE : S_LOAD_A;
                end
            end
            S_LOAD_A: state_next = S_LOAD_B;
            S_LOAD_B: state_next = S_RUN;
            S_RUN: begin
                // PC is still 0 on the first RUN cycle, so DONE is only
                // trusted from the second cycle on.
                if (run_cnt_reg != '0 && _iInstMemAddr == DONE_A) begin
                    state_next = S_READ_LO;
                end else if (run_cnt_reg == TO_LAST) begin
                    state_next = S_TOUT;
                end
            end
            S_READ_LO: state_next = (mode_reg == MODE_MUL) ? S_READ_HI : S_CHECK;
            S_READ_HI: state_next = S_CHECK;
            S_CHECK:   state_next = S_NEXT;
            S_TOUT:    state_next = S_NEXT;
            S_NEXT:    state_next = last_pair ? S_DONE : S_LOAD_A;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge _iClk) begin
        if (!_iReset) begin
            state_reg    <= S_IDLE;
            mode_reg     <= MODE_ADD;
            i_reg        <= '0;
            j_reg        <= '0;
            res_lo_reg   <= '0;
            res_hi_reg   <= '0;
            run_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
            ok_cnt_reg   <= '0;
            timeout_reg  <= 1'b0;
            bad_mode_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        mode_reg     <= mode_t'(_iMode);
                        i_reg        <= '0;
                        j_reg        <= '0;
                        err_cnt_reg  <= '0;
                        ok_cnt_reg   <= '0;
                        timeout_reg  <= 1'b0;
                        bad_mode_reg <= (_iMode == MODE_BAD);
                    end
                end
                S_LOAD_B: run_cnt_reg <= '0;
                S_RUN:    run_cnt_reg <= run_cnt_reg + 1'b1;
                S_READ_LO: res_lo_reg <= _iMemRData;
                S_READ_HI: res_hi_reg <= _iMemRData;
                S_CHECK: begin
                    if (match) begin
                        ok_cnt_reg <= ok_cnt_reg + 1'b1;
                    end else begin
                        err_cnt_reg <= err_cnt_reg + 1'b1;
                    end
                end
                S_TOUT: begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                    timeout_reg <= 1'b1;
                end
                S_NEXT: begin
                    j_reg <= j_reg + 1'b1;
                    if (&j_reg) begin
                        i_reg <= i_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and CPU control decoded from the current state.
    always_comb begin
        _oMemAddr  = '0;
        _oMemWData = '0;
        _oMemWrite = 1'b0;
        case (state_reg)
            S_LOAD_A: begin
                _oMemAddr  = OPA_A;
                _oMemWData = j_reg;
                _oMemWrite = 1'b1;
            end
            S_LOAD_B: begin
                _oMemAddr  = OPB_A;
                _oMemWData = i_reg;
                _oMemWrite = 1'b1;
            end
            S_READ_LO: _oMemAddr = RESL_A;
            S_READ_HI: _oMemAddr = RESH_A;
            default: ;
        endcase
    end

    assign _oBusOwn   = (state_reg != S_RUN);
    assign _oCpuReset = (state_reg != S_RUN);
    assign _oBusy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign _oDone     = (state_reg == S_DONE);
    assign _oTimeout  = timeout_reg;
    assign _oBadMode  = bad_mode_reg;
    assign _oErrCnt   = err_cnt_reg;
    assign _oOkCnt    = ok_cnt_reg;

endmodule

// File: doc/op_sweep_checker.md
Name: op_sweep_checker

Overview:
- Synthesizable, parametrised successor of the tp1 operand-sweep bench: drives an exhaustive (i, j) sweep against the tp1 core on-chip, for FPGA self-test without a simulator.
- Each pair: hold the CPU in reset, write operands into data RAM, release the CPU, wait for the program to reach a DONE PC, read the result, and compare it with a golden model for the selected mode.
- Sits beside tp1; owns the data-RAM bus through an external mux while `_oBusOwn`=1.

Parameters:
- DATA_W, 8, operand/RAM word width
- ADDR_W, 8, instruction and data address width
- OPA_ADDR, 0, RAM address of operand A (inner loop value j)
- OPB_ADDR, 1, RAM address of operand B (outer loop value i)
- RES_ADDR, 2, RAM address of result low word; MUL high word at RES_ADDR+1
- DONE_ADDR, 8, PC value that marks end of program
- TIMEOUT_CYC, 4096, max RUN cycles per pair

Ports:
- `_iClk`  in  1  clock
- `_iReset`  in  1  synchronous, active-low reset
- `_iStart`  in  1  one-cycle pulse; begins sweep from IDLE or DONE
- `_iMode`  in  3  operation, sampled on accepted start
- `_iInstMemAddr`  in  ADDR_W  tp1 PC (instruction address)
- `_iMemRData`  in  DATA_W  RAM read data (combinational read)
- `_oMemAddr`  out  ADDR_W  RAM address when bus owned
- `_oMemWData`  out  DATA_W  RAM write data
- `_oMemWrite`  out  1  RAM write enable
- `_oBusOwn`  out  1  1 = checker drives RAM bus
- `_oCpuReset`  out  1  active-high reset to tp1
- `_oBusy`  out  1  sweep in progress
- `_oDone`  out  1  sweep finished (level, until next start/reset)
- `_oTimeout`  out  1  sticky: any pair timed out
- `_oBadMode`  out  1  mode 7 requested
- `_oErrCnt`  out  2*DATA_W+1  mismatches
- `_oOkCnt`  out  2*DATA_W+1  matches

Behaviour:
- Reset (`_iReset`=0 at clock edge):
  - State = IDLE.
  - `_oCpuReset`=1, `_oBusOwn`=1.
  - All other outputs = 0; counters and i/j = 0.
  - Applies mid-sweep with no drain.
- Mode encoding: 0 ADD, 1 SUB, 2 MUL, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 invalid.
- Golden model, a = j, b = i:
  - ADD: (a+b) mod 2^DATA_W.
  - SUB: (a-b) mod 2^DATA_W.
  - MUL: full 2*DATA_W-bit product.
  - NAND, NOR, XOR, XNOR: bitwise over DATA_W bits.
- Start handling:
  - `_iStart` in IDLE or DONE: latch mode, clear counters/flags and i/j, go to LOAD_A.
  - `_iStart` in any other state is ignored.
  - Mode 7: set `_oBadMode`, go to DONE; no RAM writes.
- FSM (one state per cycle unless noted):
  - LOAD_A: `_oMemWrite`=1, addr OPA_ADDR, data j.
  - LOAD_B: write i at OPB_ADDR.
  - RUN: `_oCpuReset`=0, `_oBusOwn`=0.
    - Timeout counter clears on entry.
    - First RUN cycle never checks DONE (PC still 0 from reset).
    - Later cycles: `_iInstMemAddr`==DONE_ADDR → READ_LO.
    - Timeout counter reaching TIMEOUT_CYC-1 → TOUT.
  - READ_LO: `_oCpuReset`=1, `_oBusOwn`=1, addr RES_ADDR; capture rdata.
    - Next state: READ_HI if mode MUL, else CHECK.
  - READ_HI: addr RES_ADDR+1; capture rdata as high word.
  - CHECK: compare captured result with golden.
    - Non-MUL: compare DATA_W bits only.
    - Increment exactly one of ErrCnt or OkCnt.
    - Go to NEXT.
  - TOUT: ErrCnt++, `_oTimeout`=1, CPU reset, → NEXT.
  - NEXT: j++.
    - j wraps → i++.
    - i and j both wrap → DONE; else → LOAD_A.
  - DONE: `_oDone`=1, `_oBusy`=0, CPU held in reset.
- `_oBusy`=1 in every state except IDLE and DONE.
- Total pairs 2^(2*DATA_W); counter width sized so OkCnt reaches 2^(2*DATA_W) without wrap.
- `_oMemWrite`=0 outside LOAD_A/LOAD_B.
- Bus outputs are don't-care (driven 0) when `_oBusOwn`=0.

Decomposition:
- Package sweep_pkg: mode_t enum (3 bits), state_t enum, helper function for counter width.
- Sub-module sweep_golden_alu: combinational; mode, a, b → 2*DATA_W golden result.
- FSM, counters and bus control stay in op_sweep_checker.

Test Plan:
- DATA_W=2, behavioural CPU model that writes a+b and jumps to DONE after 5 cycles, mode ADD, start → `_oDone` after 16 pairs, OkCnt=16, ErrCnt=0, `_oTimeout`=0.
- Same model but result bit0 forced 1, mode XOR → ErrCnt=8, OkCnt=8 (pairs where a^b is even mismatch).
- DATA_W=2, model computes product, mode MUL → 16 two-word reads seen (RES_ADDR, RES_ADDR+1); OkCnt=16; pair (3,3) reads low=1, high=2.
- Model never reaches DONE, TIMEOUT_CYC=8 → each pair spends 8 RUN cycles; ErrCnt=16, `_oTimeout`=1, `_oDone`=1.
- Mode 7 start → `_oBadMode`=1 and `_oDone`=1 within 2 cycles; no `_oMemWrite` pulses.
- `_iReset`=0 during RUN of pair (1,2) → next cycle IDLE, `_oCpuReset`=1, counters 0; `_iStart` mid-sweep ignored (counters continue unchanged).
